// File: rtl/neander_pkg.sv
// neander_pkg
// Shared types and helpers for the NEANDER-X memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   ARB_R0/R1   : requester ids (R0 = CPU, R1 = loader/debug port)
//   rr_pick     : grant selection for the requests sampled in IDLE
package neander_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic ARB_R0 = 1'b0;
  localparam logic ARB_R1 = 1'b1;

  // req[0] = R0, req[1] = R1. A lone request always wins. On a tie, the
  // requester that was not granted last wins, unless fixed priority is set,
  // in which case R0 wins. With no request the result is unused.
  function automatic logic rr_pick(input logic [1:0] req, input logic last,
                                   input logic fixed);
    logic win;
    if (req == 2'b11) begin
      win = fixed ? ARB_R0 : ~last;
    end else if (req == 2'b10) begin
      win = ARB_R1;
    end else begin
      win = ARB_R0;
    end
    return win;
  endfunction

endpackage

// File: rtl/neander_mem_arbiter.sv
// neander_mem_arbiter
// Shares one SPI memory controller port between the NEANDER-X CPU (R0) and
// the host loader/debug port (R1). One access at a time: the winner's
// request is latched in IDLE, forwarded downstream while BUSY, and answered
// with a one-cycle ready pulse in RESP. Round-robin (or fixed R0 priority)
// arbitration, plus a watchdog that aborts a stalled downstream access.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   rN_req/rN_write/rN_addr/rN_wdata  requester N access (req held until ready)
//   rN_rdata, rN_ready              read data / one-cycle completion pulse
//   mem_req/mem_read/mem_write      downstream request held for the access
//   mem_addr, mem_data_out          latched address / write data
//   mem_data_in, mem_ready          downstream read data / completion pulse
//   grant_id                        owner of the current or last access
//   busy                            arbiter not idle
//   timeout_err, err_clr            sticky watchdog flag and its clear
module neander_mem_arbiter
  import neander_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ready,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic              mem_req,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  // A zero TIMEOUT disables the watchdog; keep the timer at least 1 bit wide.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic FIXED = (FIXED_PRIO != 0);

  arb_state_t        state_q, state_d;
  logic              id_q, id_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              prio_q, prio_d;   // requester preferred on the next tie
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;

  logic              pick;
  logic              timeout_hit;

  assign pick        = rr_pick({r1_req, r0_req}, ~prio_q, FIXED);
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    prio_d     = prio_q;
    timer_d    = timer_q;
    // A clear is overridden below if a timeout fires in the same cycle.
    err_d      = err_q & ~err_clr;

    case (state_q)
      ARB_IDLE: begin
        if (r0_req || r1_req) begin
          id_d    = pick;
          write_d = (pick == ARB_R1) ? r1_write : r0_write;
          addr_d  = (pick == ARB_R1) ? r1_addr  : r0_addr;
          wdata_d = (pick == ARB_R1) ? r1_wdata : r0_wdata;
          timer_d = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          if (!write_q) begin
            if (id_q == ARB_R1) r1_rdata_d = mem_data_in;
            else                r0_rdata_d = mem_data_in;
          end
          state_d = ARB_RESP;
        end else if (timeout_hit) begin
          // Aborted accesses report all-ones, even for writes.
          if (id_q == ARB_R1) r1_rdata_d = '1;
          else                r0_rdata_d = '1;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ARB_RESP: begin
        prio_d  = ~id_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      id_q       <= ARB_R0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      prio_q     <= ARB_R0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      prio_q     <= prio_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  // mem_req is decoded straight from the state register so an async reset
  // withdraws it immediately.
  assign mem_req      = (state_q == ARB_BUSY);
  assign mem_read     = mem_req & ~write_q;
  assign mem_write    = mem_req & write_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;
  assign r0_rdata     = r0_rdata_q;
  assign r1_rdata     = r1_rdata_q;
  assign r0_ready     = (state_q == ARB_RESP) && (id_q == ARB_R0);
  assign r1_ready     = (state_q == ARB_RESP) && (id_q == ARB_R1);
  assign grant_id     = id_q;
  assign busy         = (state_q != ARB_IDLE);
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Directed bench for neander_mem_arbiter. Instance A is round-robin with the
// default watchdog; instance B is fixed-priority with TIMEOUT=8. Both share
// the same inputs.
module tb_neander_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_write, r1_req, r1_write;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [15:0] mem_data_in;
  logic        mem_ready, err_clr;

  logic [15:0] a_r0_rdata, a_r1_rdata, a_mem_addr, a_mem_dout;
  logic        a_r0_ready, a_r1_ready, a_mem_req, a_mem_read, a_mem_write;
  logic        a_grant, a_busy, a_terr;
  logic [15:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_dout;
  logic        b_r0_ready, b_r1_ready, b_mem_req, b_mem_read, b_mem_write;
  logic        b_grant, b_busy, b_terr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neander_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0), .TIMEOUT(1024)) dut_a (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(a_r0_rdata), .r0_ready(a_r0_ready),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(a_r1_rdata), .r1_ready(a_r1_ready),
    .mem_req(a_mem_req), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_addr(a_mem_addr), .mem_data_out(a_mem_dout),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .grant_id(a_grant), .busy(a_busy), .timeout_err(a_terr), .err_clr(err_clr)
  );

  neander_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(b_r0_rdata), .r0_ready(b_r0_ready),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(b_r1_rdata), .r1_ready(b_r1_ready),
    .mem_req(b_mem_req), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_data_out(b_mem_dout),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .grant_id(b_grant), .busy(b_busy), .timeout_err(b_terr), .err_clr(err_clr)
  );

  typedef struct {
    logic        r0_req;
    logic        r0_write;
    logic [15:0] r0_addr;
    logic [15:0] r0_wdata;
    logic        r1_req;
    logic        r1_write;
    logic [15:0] r1_addr;
    logic [15:0] r1_wdata;
    int          lat;        // BUSY cycles until mem_ready is sampled
    logic [15:0] mdata;      // value driven on mem_data_in with mem_ready
    logic        exp_gnt;    // round-robin winner (instance A)
    logic        exp_gnt_fix;// fixed-priority winner (instance B)
    logic [15:0] exp_rdata;  // winner's rdata on instance A after the access
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    r0_req = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
    mem_data_in = 0; mem_ready = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  // Runs the watchdog on instance B and returns the number of BUSY cycles.
  task automatic run_timeout(output int cnt);
    cnt = 0;
    @(negedge clk);
    r0_req = 1; r0_write = 0; r0_addr = 16'h0300;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_mem_req) cnt++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t v;
    logic [15:0] e_addr, e_wdata;
    logic        e_write;
    int          cnt;

    vt[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'h1234, 1, 16'hDEAD, 1'b1, 1'b1, 16'h0000};
    vt[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1, 16'h1111, 1'b0, 1'b0, 16'h1111};
    vt[3] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0031, 16'h0000, 1, 16'h2222, 1'b1, 1'b0, 16'h2222};
    vt[4] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1, 16'h3333, 1'b0, 1'b0, 16'h3333};
    vt[5] = '{1'b1, 1'b0, 16'h0023, 16'h0000, 1'b1, 1'b0, 16'h0033, 16'h0000, 1, 16'h4444, 1'b1, 1'b0, 16'h4444};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 3, 16'hA5A5, 1'b1, 1'b1, 16'hA5A5};
    vt[7] = '{1'b1, 1'b1, 16'h0040, 16'h5678, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'hDEAD, 1'b0, 1'b0, 16'h3333};

    clear_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Reset state
    chk("rst_rdata", 32'({a_r0_rdata, a_r1_rdata}), 32'h0);
    chk("rst_addr_data", 32'({a_mem_addr, a_mem_dout}), 32'h0);
    chk("rst_ctrl", 32'({a_r0_ready, a_r1_ready, a_mem_req, a_mem_read, a_mem_write,
                         a_grant, a_busy, a_terr}), 32'h0);

    // Reset in the middle of a BUSY access
    @(negedge clk);
    r0_req = 1; r0_addr = 16'h0100;
    @(negedge clk);
    chk("midrst_pre_req", 32'(a_mem_req), 32'h1);
    chk("midrst_pre_addr", 32'(a_mem_addr), 32'h0100);
    #2 reset = 1;
    #1;
    chk("midrst_mem_req", 32'(a_mem_req), 32'h0);
    chk("midrst_addr_data", 32'({a_mem_addr, a_mem_dout}), 32'h0);
    chk("midrst_ctrl", 32'({a_r0_ready, a_r1_ready, a_mem_req, a_mem_read, a_mem_write,
                            a_grant, a_busy, a_terr}), 32'h0);
    r0_req = 0; r0_addr = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_rst", 32'({a_busy, a_mem_req}), 32'h0);
    end

    // Table-driven accesses
    for (int k = 0; k < 8; k++) begin
      v = vt[k];
      @(negedge clk);
      r0_req = v.r0_req; r0_write = v.r0_write; r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
      r1_req = v.r1_req; r1_write = v.r1_write; r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
      e_addr  = v.exp_gnt ? v.r1_addr  : v.r0_addr;
      e_wdata = v.exp_gnt ? v.r1_wdata : v.r0_wdata;
      e_write = v.exp_gnt ? v.r1_write : v.r0_write;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", k), 32'(a_mem_req), 32'h1);
      chk($sformatf("v%0d_grant", k), 32'(a_grant), 32'(v.exp_gnt));
      chk($sformatf("v%0d_grant_fixed", k), 32'(b_grant), 32'(v.exp_gnt_fix));
      chk($sformatf("v%0d_mem_addr", k), 32'(a_mem_addr), 32'(e_addr));
      chk($sformatf("v%0d_rw", k), 32'({a_mem_read, a_mem_write}), 32'({~e_write, e_write}));
      if (e_write) chk($sformatf("v%0d_mem_dout", k), 32'(a_mem_dout), 32'(e_wdata));
      for (int j = 1; j < v.lat; j++) begin
        @(negedge clk);
        chk($sformatf("v%0d_wait_req", k), 32'({a_mem_req, a_r0_ready, a_r1_ready}), 32'h4);
      end
      mem_ready = 1; mem_data_in = v.mdata;
      @(negedge clk);
      mem_ready = 0; mem_data_in = 16'h0000;
      chk($sformatf("v%0d_ready", k), 32'({a_r1_ready, a_r0_ready}),
          v.exp_gnt ? 32'h2 : 32'h1);
      chk($sformatf("v%0d_ready_fixed", k), 32'({b_r1_ready, b_r0_ready}),
          v.exp_gnt_fix ? 32'h2 : 32'h1);
      chk($sformatf("v%0d_rdata", k), 32'(v.exp_gnt ? a_r1_rdata : a_r0_rdata),
          32'(v.exp_rdata));
      chk($sformatf("v%0d_req_drop", k), 32'(a_mem_req), 32'h0);
      r0_req = 0; r1_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", k), 32'({a_r1_ready, a_r0_ready, a_busy}), 32'h0);
    end

    // R1 write; R0 arrives during BUSY and is served on the next IDLE
    @(negedge clk);
    r1_req = 1; r1_write = 1; r1_addr = 16'h8000; r1_wdata = 16'h1234;
    @(negedge clk);
    chk("t4_grant", 32'(a_grant), 32'h1);
    chk("t4_write", 32'({a_mem_write, a_mem_read}), 32'h2);
    r0_req = 1; r0_write = 0; r0_addr = 16'h0200;
    r1_addr = 16'hFFFF; r1_wdata = 16'h0000;
    @(negedge clk);
    chk("t4_stable", 32'({a_mem_addr, a_mem_dout}), 32'h8000_1234);
    chk("t4_grant_hold", 32'(a_grant), 32'h1);
    mem_ready = 1; mem_data_in = 16'h7777;
    @(negedge clk);
    mem_ready = 0;
    chk("t4_r1_first", 32'({a_r1_ready, a_r0_ready}), 32'h2);
    chk("t4_write_keeps_rdata", 32'(a_r1_rdata), 32'hA5A5);
    r1_req = 0; r1_write = 0;
    @(negedge clk);
    chk("t4_idle_gap", 32'(a_busy), 32'h0);
    @(negedge clk);
    chk("t4_r0_grant", 32'(a_grant), 32'h0);
    chk("t4_r0_addr", 32'(a_mem_addr), 32'h0200);
    chk("t4_r0_read", 32'({a_mem_req, a_mem_read}), 32'h3);
    mem_ready = 1; mem_data_in = 16'h9999;
    @(negedge clk);
    mem_ready = 0; mem_data_in = 0;
    chk("t4_r0_ready", 32'({a_r1_ready, a_r0_ready}), 32'h1);
    chk("t4_r0_rdata", 32'(a_r0_rdata), 32'h9999);
    r0_req = 0;
    @(negedge clk);

    // mem_ready while IDLE is ignored
    @(negedge clk);
    mem_ready = 1; mem_data_in = 16'h5555;
    @(negedge clk);
    mem_ready = 0; mem_data_in = 0;
    chk("idle_rdy_state", 32'({a_busy, a_r0_ready, a_r1_ready}), 32'h0);
    chk("idle_rdy_rdata", 32'(a_r0_rdata), 32'h9999);
    @(negedge clk);
    chk("idle_rdy_after", 32'({a_busy, a_r0_ready, a_r1_ready}), 32'h0);

    // Watchdog on instance B (TIMEOUT=8)
    do_reset();
    run_timeout(cnt);
    chk("to_busy_cycles", 32'(cnt), 32'd8);
    chk("to_ready", 32'({b_r1_ready, b_r0_ready}), 32'h1);
    chk("to_rdata", 32'(b_r0_rdata), 32'hFFFF);
    chk("to_err", 32'(b_terr), 32'h1);
    chk("to_a_unaffected", 32'({a_mem_req, a_terr}), 32'h2);
    r0_req = 0;
    @(negedge clk);
    chk("to_pulse_end", 32'({b_r0_ready, b_terr}), 32'h1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(b_terr), 32'h1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("to_err_clr", 32'(b_terr), 32'h0);

    // Set wins over a simultaneous clear
    do_reset();
    err_clr = 1;
    run_timeout(cnt);
    chk("to2_busy_cycles", 32'(cnt), 32'd8);
    chk("to2_set_wins", 32'(b_terr), 32'h1);
    r0_req = 0;
    @(negedge clk);
    chk("to2_then_clr", 32'(b_terr), 32'h0);
    err_clr = 0;

    do_reset();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
